sa_skew_feeder: RTL

- Edge feeder for the torus systolic array; sits directly upstream of the PE row/column boundary and drives the PE `A_in`/`B_in` operand ports.
- Accepts one N-lane operand vector per valid/ready handshake and buffers vectors in a small FIFO.
- Emits vectors diagonally skewed (lane i delayed i cycles) so operands meet the correct partial sums in free-running PEs.
- Inserts zero bubbles on underflow and drains the skew pipe after the last vector of a tile, then pulses `done_o`.

---
 rtl/sa_skew_feeder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: edge feeder for the torus systolic array.
// Buffers N-lane operand vectors in a small FIFO and emits them diagonally
// skewed (lane i delayed i extra cycles) toward the PE A_in/B_in ports.
// Zero bubbles are inserted on underflow; after the final vector of a tile
// the skew pipe drains and done_o pulses when the last lane is presented.
// Optional feature macro: SKEW_BUBBLE_CNT_EN adds a saturating 16-bit count
// of STREAM cycles that found the FIFO empty (port bubble_cnt_o).
module sa_skew_feeder #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             v_i,
  input  logic [N*W-1:0]   data_i,
  input  logic             last_i,
  output logic             ready_o,
  output logic [N*W-1:0]   a_o,
  output logic [N-1:0]     v_o,
  output logic             done_o,
  output logic             busy_o
`ifdef SKEW_BUBBLE_CNT_EN
  ,output logic [15:0]     bubble_cnt_o
`endif
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int DW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [N*W-1:0]  r_mem_dat [DEPTH];
  logic [DEPTH-1:0] r_mem_last;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;

  state_t          r_state;
  logic [DW-1:0]   r_dcnt;
  logic            r_done;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [N*W-1:0]  w_rd_dat;
  logic            w_rd_last;

  assign w_full    = (r_count == CNTW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign ready_o   = !w_full && !reset;
  assign w_push    = v_i && ready_o;
  assign w_pop     = (r_state != S_DRAIN) && !w_empty;
  assign w_rd_dat  = r_mem_dat[r_rptr];
  assign w_rd_last = r_mem_last[r_rptr];
  assign busy_o    = (r_state != S_IDLE) || !w_empty;
  assign done_o    = r_done;

  // FIFO storage: data entries carry no reset; validity lives in r_count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_dat[r_wptr]  <= data_i;
      r_mem_last[r_wptr] <= last_i;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tile sequencer: pops while streaming, then holds off pops for N drain cycles.
  // done_o is registered one cycle early so it coincides with the last lane.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_STREAM: begin
          if (w_pop) begin
            if (w_rd_last) begin
              r_state <= S_DRAIN;
              r_dcnt  <= DW'(N - 1);
              r_done  <= (N == 1);
            end else begin
              r_state <= S_STREAM;
            end
          end
        end
        S_DRAIN: begin
          r_done <= (r_dcnt == DW'(1));
          if (r_dcnt == '0) r_state <= S_IDLE;
          else              r_dcnt  <= r_dcnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Skew pipe: lane i is i+1 registers deep and shifts every cycle.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [W-1:0] r_dat_p [gi+1];
    logic [gi:0]  r_vld_p;

    // Stage 0 loads the popped lane or a zero bubble; later stages shift.
    always_ff @(posedge clk_i) begin
      if (reset) begin
        for (int j = 0; j <= gi; j++) r_dat_p[j] <= '0;
        r_vld_p <= '0;
      end else begin
        r_dat_p[0] <= w_pop ? w_rd_dat[gi*W +: W] : '0;
        r_vld_p[0] <= w_pop;
        for (int j = 1; j <= gi; j++) begin
          r_dat_p[j] <= r_dat_p[j-1];
          r_vld_p[j] <= r_vld_p[j-1];
        end
      end
    end

    assign a_o[gi*W +: W] = r_dat_p[gi];
    assign v_o[gi]        = r_vld_p[gi];
  end

`ifdef SKEW_BUBBLE_CNT_EN
  logic [15:0] r_bub_cnt;

  // Saturating count of streaming cycles that found nothing to pop.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_bub_cnt <= '0;
    end else if ((r_state == S_STREAM) && w_empty && (r_bub_cnt != 16'hFFFF)) begin
      r_bub_cnt <= r_bub_cnt + 16'd1;
    end
  end

  assign bubble_cnt_o = r_bub_cnt;
`endif

endmodule
